// File: rtl/mips_boot_ctrl_if.sv
// Program-load stream plus instruction-memory write bus for the boot controller.
// Latency: none (wires only).
// Backpressure: ld_ready from the slave qualifies every ld_valid/ld_data/ld_last beat.
//
// Signals:
//   ld_valid, ld_data, ld_last  program word stream, source -> controller
//   ld_ready                    controller accepts a word this cycle
//   imem_we, imem_addr, imem_wdata  registered instruction-memory write port
//
// Modports:
//   master  program source / memory side (drives the stream, observes the writes)
//   slave   the boot controller
interface mips_boot_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/mips_boot_ctrl.sv
// Boot/run controller: streams a program into instruction memory from address 0, then releases and watches the core.
// Latency: handshake at edge k -> memory write in cycle k+1; last-word handshake at edge k -> core out of reset at k+2.
// Backpressure: ld_ready is a pure decode of LOAD (1 word/clk, no stalls inside LOAD); low in every other state.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle load request, honoured in IDLE, DONE and ERR only
//   ld (slave)        program word stream in, registered instruction-memory write out
//   core_reset        active-high reset to the core; low only in RUN and DONE
//   core_pc           core program counter (byte address), compared against HALT_PC
//   busy              LOAD, DRAIN or RUN
//   done / timeout    run ended at HALT_PC / run-cycle budget exhausted
//   overflow          more words offered than the memory holds
//   word_count        words written this load (saturates at 2^ADDR_W)
//   checksum          modulo-2^DATA_W sum of the written words
//   run_cycles        cycles spent in RUN
module mips_boot_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] HALT_PC    = 32'h0000_0050,
    parameter int          MAX_CYCLES = 1024,
    localparam int         CYC_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mips_boot_ctrl_if.slave   ld,
    output logic              core_reset,
    input  logic [31:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum,
    output logic [CYC_W-1:0]  run_cycles
);

    // Memory depth expressed in word_count's width so the full-memory compare is exact.
    localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] RC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] RC_LAST = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // One-cycle action strobes decoded from the current state and inputs.
    logic clr;        // start accepted: wipe counters and flags
    logic wr;         // accepted word fits in memory: write and count it
    logic ovf;        // accepted word with memory already full
    logic rc_inc;     // one more RUN cycle
    logic set_done;
    logic set_to;
    logic hs;

    // Handshake is valid gated by the registered state only, so ld_ready
    // never depends combinationally on ld_valid.
    assign hs = ld.ld_valid && (state == S_LOAD);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        wr        = 1'b0;
        ovf       = 1'b0;
        rc_inc    = 1'b0;
        set_done  = 1'b0;
        set_to    = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    clr       = 1'b1;
                end
            end

            S_LOAD: begin
                if (hs) begin
                    // A full memory takes precedence over ld_last: the extra
                    // word is rejected and the load is abandoned.
                    if (word_count == DEPTH) begin
                        ovf       = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        wr = 1'b1;
                        if (ld.ld_last) begin
                            state_nxt = S_DRAIN;
                        end
                    end
                end
            end

            // Gives the final registered write one cycle to land in memory
            // before the core starts fetching.
            S_DRAIN: begin
                state_nxt = S_RUN;
            end

            S_RUN: begin
                rc_inc = 1'b1;
                // Halt is tested first so it wins over a coincident timeout.
                if (core_pc == HALT_PC) begin
                    set_done  = 1'b1;
                    state_nxt = S_DONE;
                end else if (run_cycles == RC_LAST) begin
                    set_to    = 1'b1;
                    state_nxt = S_ERR;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: memory write port, counters and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld.imem_we    <= 1'b0;
            ld.imem_addr  <= '0;
            ld.imem_wdata <= '0;
            word_count    <= '0;
            checksum      <= '0;
            run_cycles    <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            // Write enable is a single-cycle pulse per accepted word.
            ld.imem_we <= wr;
            if (wr) begin
                ld.imem_addr  <= word_count[ADDR_W-1:0];
                ld.imem_wdata <= ld.ld_data;
                word_count    <= word_count + WC_ONE;
                checksum      <= checksum + ld.ld_data;
            end

            if (clr) begin
                word_count <= '0;
                checksum   <= '0;
                run_cycles <= '0;
                done       <= 1'b0;
                timeout    <= 1'b0;
                overflow   <= 1'b0;
            end

            if (ovf) begin
                overflow <= 1'b1;
            end

            // RUN exits no later than run_cycles == MAX_CYCLES-1, so the
            // counter peaks at MAX_CYCLES and cannot wrap.
            if (rc_inc) begin
                run_cycles <= run_cycles + RC_ONE;
            end

            if (set_done) begin
                done <= 1'b1;
            end

            if (set_to) begin
                timeout <= 1'b1;
            end
        end
    end

    // Core is held in reset everywhere except RUN and DONE; in DONE it keeps
    // spinning in its halt loop so its state stays observable.
    assign core_reset  = !((state == S_RUN) || (state == S_DONE));
    assign busy        = (state == S_LOAD) || (state == S_DRAIN) || (state == S_RUN);
    assign ld.ld_ready = (state == S_LOAD);

endmodule

// File: tb/tb_mips_boot_ctrl.sv
`timescale 1ns/1ps
// Bench for mips_boot_ctrl: random program loads and core-PC stubs scored against a reference model.
// Expected writes and end-of-run status are queued when stimulus is issued; a monitor pops and compares.
// Bench parameters shrink memory to 4 words and the run budget to 24 cycles to reach the boundaries quickly.
module tb_mips_boot_ctrl;

    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 2;
    localparam int          MAX_CYCLES = 24;
    localparam logic [31:0] HALT_PC    = 32'h0000_0050;
    localparam int          CYC_W      = $clog2(MAX_CYCLES + 1);
    localparam int          DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              core_reset;
    logic [31:0]       core_pc;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overflow;
    logic [ADDR_W:0]   word_count;
    logic [DATA_W-1:0] checksum;
    logic [CYC_W-1:0]  run_cycles;

    mips_boot_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mips_boot_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .HALT_PC    (HALT_PC),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ld         (bus),
        .core_reset (core_reset),
        .core_pc    (core_pc),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          when;
    } wr_t;

    typedef struct {
        bit          done;
        bit          timeout;
        bit          overflow;
        bit          core_reset;
        int          wc;
        logic [31:0] sum;
        int          rc;
    } st_t;

    wr_t wq[$];
    st_t sq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core stub: PC holds pc_start while in reset, then advances by pc_step per cycle.
    logic [31:0] pc_start = 32'h0;
    logic [31:0] pc_step  = 32'h4;
    int          pc_idx;
    initial begin
        core_pc = 32'h0;
        pc_idx  = 0;
        forever begin
            @(negedge clk);
            if (core_reset) begin
                pc_idx  = 0;
                core_pc = pc_start;
            end else begin
                core_pc = pc_start + pc_step * 32'(pc_idx);
                pc_idx++;
            end
        end
    end

    // Run outcome from the stub's PC sequence: the i-th RUN cycle sees
    // pc_start + i*pc_step; a match ends the run after i+1 cycles, otherwise
    // the budget runs out after MAX_CYCLES cycles.
    function automatic st_t run_model(input int wc, input logic [31:0] sum);
        st_t s;
        bit  hit = 1'b0;
        s.wc         = wc;
        s.sum        = sum;
        s.overflow   = 1'b0;
        s.done       = 1'b0;
        s.timeout    = 1'b1;
        s.rc         = MAX_CYCLES;
        s.core_reset = 1'b1;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            if (!hit && (pc_start + pc_step * 32'(i)) == HALT_PC) begin
                hit          = 1'b1;
                s.done       = 1'b1;
                s.timeout    = 1'b0;
                s.rc         = i + 1;
                s.core_reset = 1'b0;
            end
        end
        return s;
    endfunction

    // Monitor: scores every memory write and the status at each end of busy.
    wr_t mw;
    st_t ms;
    bit  prev_busy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.imem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL wr_unexpected: imem_we=1 addr=%0d data=0x%h, required no write", bus.imem_addr, bus.imem_wdata);
                end else begin
                    mw = wq.pop_front();
                    check("wr_addr", 64'(bus.imem_addr), 64'(mw.addr));
                    check("wr_data", 64'(bus.imem_wdata), 64'(mw.data));
                    check("wr_cycle", 64'(cyc), 64'(mw.when));
                end
            end
            if (prev_busy && !busy) begin
                if (sq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL st_unexpected: busy fell with no expected status");
                end else begin
                    ms = sq.pop_front();
                    check("st_done", 64'(done), 64'(ms.done));
                    check("st_timeout", 64'(timeout), 64'(ms.timeout));
                    check("st_overflow", 64'(overflow), 64'(ms.overflow));
                    check("st_core_reset", 64'(core_reset), 64'(ms.core_reset));
                    check("st_word_count", 64'(word_count), 64'(ms.wc));
                    check("st_checksum", 64'(checksum), 64'(ms.sum));
                    check("st_run_cycles", 64'(run_cycles), 64'(ms.rc));
                end
            end
            prev_busy = busy;
        end
    end

    // Starts a load and streams n words (taken from words[] while it lasts,
    // random afterwards). Expected writes and final status are queued as
    // each handshake is issued.
    task automatic do_load(input logic [31:0] words[$], input int n, input bit with_last,
                           input bit gaps, input bit noise);
        int          wc    = 0;
        int          sent  = 0;
        int          guard = 0;
        logic [31:0] sum   = '0;
        bit          rdy;
        bit          stop  = 1'b0;
        bit          ovf   = 1'b0;
        wr_t         w;
        st_t         s;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clr_word_count", 64'(word_count), 64'd0);
        check("clr_checksum", 64'(checksum), 64'd0);
        check("clr_run_cycles", 64'(run_cycles), 64'd0);
        check("clr_flags", {61'd0, done, timeout, overflow}, 64'd0);
        check("load_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("load_core_reset", 64'(core_reset), 64'd1);

        while (!stop && guard < 200) begin
            guard++;
            rdy          = bus.ld_ready;
            bus.ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ld_data  = (sent < words.size()) ? words[sent] : $urandom();
            bus.ld_last  = with_last && (sent == n - 1);
            start        = noise && ($urandom_range(0, 3) == 0);
            if (bus.ld_valid && rdy) begin
                if (wc < DEPTH) begin
                    w.addr = wc;
                    w.data = bus.ld_data;
                    w.when = cyc + 1;
                    wq.push_back(w);
                    wc++;
                    sum += bus.ld_data;
                end else begin
                    ovf = 1'b1;
                end
                sent++;
                if (ovf || bus.ld_last || sent == n) begin
                    stop = 1'b1;
                    if (ovf) begin
                        s.done       = 1'b0;
                        s.timeout    = 1'b0;
                        s.overflow   = 1'b1;
                        s.core_reset = 1'b1;
                        s.wc         = wc;
                        s.sum        = sum;
                        s.rc         = 0;
                    end else begin
                        s = run_model(wc, sum);
                    end
                    sq.push_back(s);
                end
            end
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        start        = 1'b0;

        if (!stop) begin
            nvec++;
            nmis++;
            $display("FAIL load_stall: only %0d of %0d words accepted, required all", sent, n);
        end else if (ovf) begin
            check("ovf_ld_ready", 64'(bus.ld_ready), 64'd0);
            check("ovf_core_reset", 64'(core_reset), 64'd1);
            check("ovf_busy", 64'(busy), 64'd0);
        end else begin
            // One cycle after the last handshake: DRAIN.
            check("drain_core_reset", 64'(core_reset), 64'd1);
            check("drain_ld_ready", 64'(bus.ld_ready), 64'd0);
            check("drain_busy", 64'(busy), 64'd1);
            @(negedge clk);
            // Two cycles after: first RUN cycle.
            check("run_core_reset", 64'(core_reset), 64'd0);
            check("run_busy", 64'(busy), 64'd1);
            check("run_first_rc", 64'(run_cycles), 64'd0);
        end
    endtask

    // Waits for the run to end, optionally pulsing start while in RUN.
    task automatic wait_end(input bit noise);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            start = (noise && busy && !core_reset) ? 1'($urandom_range(0, 1)) : 1'b0;
            k++;
        end
        start = 1'b0;
        if (busy) begin
            nvec++;
            nmis++;
            $display("FAIL wait_end: busy still 1 after %0d cycles, required 0", k);
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within 300us");
        $fatal(1, "watchdog");
    end

    logic [31:0] dw[$];
    logic [31:0] empty_q[$];
    wr_t         w0;
    st_t         rs;

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;

        // Reset values.
        #3;
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_flags", {60'd0, busy, done, timeout, overflow}, 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_run_cycles", 64'(run_cycles), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("idle_core_reset", 64'(core_reset), 64'd1);

        // Reference program, PC stepping 0,4,...,0x50.
        pc_start = 32'h0;
        pc_step  = 32'h4;
        dw = {32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
        do_load(dw, 3, 1'b1, 1'b0, 1'b0);
        wait_end(1'b0);
        check("ref_checksum", 64'(checksum), 64'h411A_5028);
        check("ref_word_count", 64'(word_count), 64'd3);
        check("ref_run_cycles", 64'(run_cycles), 64'd21);
        @(negedge clk);
        check("done_rc_frozen", 64'(run_cycles), 64'd21);
        check("done_core_reset", 64'(core_reset), 64'd0);
        check("done_busy", 64'(busy), 64'd0);

        // Restart from DONE with a single word.
        pc_step = 32'h8;
        do_load(empty_q, 1, 1'b1, 1'b0, 1'b0);
        wait_end(1'b0);

        // PC stuck at 0: budget expires.
        pc_step = 32'h0;
        do_load(empty_q, 2, 1'b1, 1'b0, 1'b0);
        wait_end(1'b0);
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_done", 64'(done), 64'd0);
        check("to_run_cycles", 64'(run_cycles), 64'(MAX_CYCLES));
        check("to_core_reset", 64'(core_reset), 64'd1);

        // HALT_PC reached exactly on the final budget edge: halt wins.
        pc_start = HALT_PC - 32'(4 * (MAX_CYCLES - 1));
        pc_step  = 32'h4;
        do_load(empty_q, 2, 1'b1, 1'b0, 1'b0);
        wait_end(1'b0);
        check("edge_done", 64'(done), 64'd1);
        check("edge_timeout", 64'(timeout), 64'd0);
        check("edge_run_cycles", 64'(run_cycles), 64'(MAX_CYCLES));

        // One word more than the memory holds, no ld_last.
        do_load(empty_q, DEPTH + 1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_word_count", 64'(word_count), 64'(DEPTH));

        // Randomised loads, valid gaps, stray start pulses, varied PC stubs.
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 5))
                0: begin pc_start = 32'h0;        pc_step = 32'h4;  end
                1: begin pc_start = 32'h0;        pc_step = 32'h8;  end
                2: begin pc_start = 32'h0;        pc_step = 32'h0;  end
                3: begin pc_start = 32'h0;        pc_step = 32'hC;  end
                4: begin pc_start = HALT_PC;      pc_step = 32'h0;  end
                default: begin pc_start = 32'h40; pc_step = 32'h4;  end
            endcase
            if ($urandom_range(0, 4) == 0) begin
                do_load(empty_q, DEPTH + 1, 1'b0, 1'b1, 1'b1);
                repeat (2) @(negedge clk);
            end else begin
                do_load(empty_q, int'($urandom_range(1, DEPTH)), 1'b1, 1'b1, 1'b1);
                wait_end(1'b1);
            end
        end

        // Reset mid-LOAD: the second word's write is dropped.
        pc_start = 32'h0;
        pc_step  = 32'h4;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_last  = 1'b0;
        bus.ld_data  = $urandom();
        w0.addr = 0;
        w0.data = bus.ld_data;
        w0.when = cyc + 1;
        wq.push_back(w0);
        @(negedge clk);
        bus.ld_data   = $urandom();
        rs.done       = 1'b0;
        rs.timeout    = 1'b0;
        rs.overflow   = 1'b0;
        rs.core_reset = 1'b1;
        rs.wc         = 0;
        rs.sum        = '0;
        rs.rc         = 0;
        sq.push_back(rs);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_imem_we", 64'(bus.imem_we), 64'd0);
        check("arst_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("arst_core_reset", 64'(core_reset), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_word_count", 64'(word_count), 64'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Recovery after reset.
        do_load(empty_q, 2, 1'b1, 1'b0, 1'b0);
        wait_end(1'b0);

        repeat (3) @(negedge clk);
        check("left_writes", 64'(wq.size()), 64'd0);
        check("left_status", 64'(sq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
